// File: rtl/conv_window_feeder.sv
// Column feeder for the 5x5 convolution datapath: buffers four image rows in a
// line-store ring and emits, per pixel in raster order, the vertical 5-pixel column centred on it.
package conv_pkg;
    localparam int PIXEL_W     = 8;
    localparam int IMAGE_MAX_W = 4096;
    localparam int IMAGE_MAX_H = 4096;
    localparam int KERNEL_N    = 5;

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef pixel_t [KERNEL_N-1:0] pixel_span_t;
    typedef pixel_span_t [KERNEL_N-1:0] kernel_t;

    // A set flag means that neighbour of the centre lies outside the frame.
    typedef struct packed {
        logic w2;
        logic w1;
        logic e1;
        logic e2;
        logic n2;
        logic n1;
        logic s1;
        logic s2;
    } kernel_pos_t;

    localparam int KERNEL_POS_W = $bits(kernel_pos_t);
endpackage

module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int LINE_MAX_W  = IMAGE_MAX_W,
    parameter int FRAME_MAX_H = IMAGE_MAX_H,
    localparam int X_W = $clog2(LINE_MAX_W),
    localparam int Y_W = $clog2(FRAME_MAX_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [X_W:0]      cfg_w,
    input  logic [Y_W:0]      cfg_h,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  pixel_t            in_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output pixel_span_t       out_col,
    output kernel_pos_t       out_pos,
    output logic [X_W-1:0]    out_x,
    output logic [Y_W-1:0]    out_y,
    output logic              out_sof,
    output logic              out_eof,
    output logic [1:0]        dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
    // depends on ready, and a held (valid && !ready) output keeps every out_* field stable.
    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [X_W:0]     w_q, w_d;
    logic [Y_W:0]     h_q, h_d;
    logic [X_W-1:0]   ix_q, ix_d, cx_q, cx_d;
    logic [Y_W-1:0]   iy_q, iy_d, cy_q, cy_d;

    logic             out_valid_q, out_sof_q, out_eof_q;
    pixel_span_t      out_col_q;
    kernel_pos_t      out_pos_q;
    logic [X_W-1:0]   out_x_q;
    logic [Y_W-1:0]   out_y_q;

    pixel_t           line_mem [4][LINE_MAX_W];

    logic             adv, emit, wr_en;
    logic [1:0]       wr_slot;
    logic [X_W-1:0]   wr_addr;
    logic             in_row_end, in_last, c_row_end, c_last;
    logic [4:0]       lane_ok;
    pixel_span_t      col_c;
    kernel_pos_t      pos_c;

    assign adv = !out_valid_q || out_ready;

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        h_d      = h_q;
        ix_d     = ix_q;
        iy_d     = iy_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        in_ready = 1'b0;
        emit     = 1'b0;
        wr_en    = 1'b0;
        wr_slot  = iy_q[1:0];
        wr_addr  = ix_q;

        in_row_end = ({1'b0, ix_q} == w_q - (X_W+1)'(1));
        in_last    = in_row_end && ({1'b0, iy_q} == h_q - (Y_W+1)'(1));
        c_row_end  = ({1'b0, cx_q} == w_q - (X_W+1)'(1));
        c_last     = c_row_end && ({1'b0, cy_q} == h_q - (Y_W+1)'(1));

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && in_sof) begin
                    w_d     = cfg_w;
                    h_d     = cfg_h;
                    wr_en   = 1'b1;
                    wr_slot = 2'd0;
                    wr_addr = '0;
                    ix_d    = X_W'(1);
                    iy_d    = '0;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (in_row_end) begin
                        ix_d = '0;
                        iy_d = iy_q + Y_W'(1);
                        if (iy_q[0]) state_d = RUN;
                    end else begin
                        ix_d = ix_q + X_W'(1);
                    end
                end
            end
            RUN: begin
                in_ready = adv;
                if (in_valid && adv) begin
                    wr_en = 1'b1;
                    emit  = 1'b1;
                    if (in_last) begin
                        ix_d    = '0;
                        iy_d    = '0;
                        state_d = FLUSH;
                    end else if (in_row_end) begin
                        ix_d = '0;
                        iy_d = iy_q + Y_W'(1);
                    end else begin
                        ix_d = ix_q + X_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (adv) begin
                    emit = 1'b1;
                    if (c_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (emit) begin
            if (c_last) begin
                cx_d = '0;
                cy_d = '0;
            end else if (c_row_end) begin
                cx_d = '0;
                cy_d = cy_q + Y_W'(1);
            end else begin
                cx_d = cx_q + X_W'(1);
            end
        end
    end

    // Lane k holds row cy-2+k, whose ring slot is (cy+k+2) mod 4; in RUN the bottom lane
    // is the pixel being accepted, which is not in the store yet.
    always_comb begin
        lane_ok[0] = cy_q >= Y_W'(2);
        lane_ok[1] = cy_q != '0;
        lane_ok[2] = 1'b1;
        lane_ok[3] = ({1'b0, cy_q} + (Y_W+1)'(1)) < h_q;
        lane_ok[4] = ({1'b0, cy_q} + (Y_W+1)'(2)) < h_q;
        for (int k = 0; k < 5; k++) begin
            col_c[k] = '0;
            if (lane_ok[k]) begin
                if (k == 4 && state_q == RUN) col_c[k] = in_pixel;
                else col_c[k] = line_mem[cy_q[1:0] + 2'(k + 2)][cx_q];
            end
        end
        pos_c.w1 = (cx_q == '0);
        pos_c.w2 = (cx_q < X_W'(2));
        pos_c.e1 = c_row_end;
        pos_c.e2 = ({1'b0, cx_q} + (X_W+1)'(2)) >= w_q;
        pos_c.n2 = !lane_ok[0];
        pos_c.n1 = !lane_ok[1];
        pos_c.s1 = !lane_ok[3];
        pos_c.s2 = !lane_ok[4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            h_q     <= '0;
            ix_q    <= '0;
            iy_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            ix_q    <= ix_d;
            iy_q    <= iy_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_col_q   <= '0;
            out_pos_q   <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
        end else if (emit) begin
            out_valid_q <= 1'b1;
            out_sof_q   <= (cx_q == '0) && (cy_q == '0);
            out_eof_q   <= c_last;
            out_col_q   <= col_c;
            out_pos_q   <= pos_c;
            out_x_q     <= cx_q;
            out_y_q     <= cy_q;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Store contents are deliberately left unreset; a row is always written before it is read.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) line_mem[wr_slot][wr_addr] <= in_pixel;
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign out_col   = out_col_q;
    assign out_pos   = out_pos_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: random frames compared column by column against a
// model built directly from image arrays and the frame-edge rules.
module tb_conv_window_feeder;
    localparam int REC_W = 74;
    localparam int PIX_TIMEOUT = 400;

    logic                      clk, rst;
    logic [12:0]               cfg_w, cfg_h;
    logic                      in_valid, in_ready, in_sof;
    logic [7:0]                in_pixel;
    logic                      out_valid, out_ready, out_sof, out_eof;
    conv_pkg::pixel_span_t     out_col;
    conv_pkg::kernel_pos_t     out_pos;
    logic [11:0]               out_x, out_y;
    logic [1:0]                dbg_state;

    logic [7:0]                img [0:7][0:4095];
    logic [REC_W-1:0]          exp_q[$];
    logic [REC_W-1:0]          got_q[$];
    int                        tests_run = 0;
    int                        fails = 0;
    int                        rdy_mode = 0;

    conv_window_feeder dut (
        .clk(clk), .rst(rst), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col), .out_pos(out_pos),
        .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .out_eof(out_eof),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // out_ready: mode 0 always high, mode 1 random, mode 2 driven by the test itself
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // collect every accepted output column
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready)
                got_q.push_back({out_x, out_y, out_sof, out_eof, out_pos, out_col});
        end
    end

    // reference model: column centred on (x,y) from the stored image, rows outside the frame are 0
    task automatic build_expected(input int w, input int h);
        conv_pkg::pixel_span_t c;
        conv_pkg::kernel_pos_t p;
        int r;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                for (int k = 0; k < 5; k++) begin
                    r = y - 2 + k;
                    c[k] = (r < 0 || r >= h) ? 8'd0 : img[r][x];
                end
                p = '0;
                p.w1 = (x < 1);
                p.w2 = (x < 2);
                p.e1 = (x > w - 2);
                p.e2 = (x > w - 3);
                p.n1 = (y < 1);
                p.n2 = (y < 2);
                p.s1 = (y > h - 2);
                p.s2 = (y > h - 3);
                exp_q.push_back({12'(x), 12'(y), (x == 0 && y == 0), (x == w - 1 && y == h - 1), p, c});
            end
        end
    endtask

    task automatic gen_image(input int w, input int h, input bit ramp);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                img[y][x] = ramp ? 8'(10 * y + x) : 8'($urandom_range(0, 255));
    endtask

    // driver: called at posedge+1, returns at posedge+1 after the pixel is accepted
    task automatic put_pixel(input logic [7:0] p, input logic sof, output int waited);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_pixel = p;
        in_sof   = sof;
        @(negedge clk);
        while (!in_ready && n < PIX_TIMEOUT) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests_run++;
            fails++;
            $display("FAIL pixel_accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        waited   = n;
    endtask

    task automatic send_frame(input int w, input int h, input int npix, input int sof_extra,
                              input bit gaps, output int first_wait);
        int wt;
        first_wait = 0;
        cfg_w = 13'(w);
        cfg_h = 13'(h);
        for (int i = 0; i < npix; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            put_pixel(img[i / w][i % w], (i == 0) || (i == sof_extra), wt);
            if (i == 0) begin
                first_wait = wt;
                cfg_w = 13'($urandom_range(5, 4096));
                cfg_h = 13'($urandom_range(5, 4096));
            end
        end
    endtask

    task automatic wait_drain(input int n, input int bound);
        int c;
        c = 0;
        while (got_q.size() < n && c < bound) begin
            @(posedge clk);
            c++;
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_pixel = '0;
        cfg_w = 13'd5;
        cfg_h = 13'd5;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if ({out_valid, out_sof, out_eof} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: valid/sof/eof=%b required 000", {out_valid, out_sof, out_eof});
        end
        tests_run++;
        if ({out_col, out_pos, out_x, out_y} !== '0) begin
            fails++;
            $display("FAIL reset_fields: col=%h pos=%h x=%0d y=%0d required all 0", out_col, out_pos, out_x, out_y);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        got_q.delete();
    endtask

    task automatic test_basic();
        int wt;
        logic [REC_W-1:0] r;
        exp_q.delete();
        got_q.delete();
        rdy_mode = 0;
        gen_image(5, 5, 1'b1);
        build_expected(5, 5);
        send_frame(5, 5, 25, -1, 1'b0, wt);
        wait_drain(25, 200);
        tests_run++;
        if (got_q.size() !== 25) begin
            fails++;
            $display("FAIL basic_count: got %0d columns required 25", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL basic_col[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        if (got_q.size() >= 25) begin
            r = got_q[0];
            tests_run++;
            if (r[73:39] !== {24'd0, 1'b1, 1'b0, 8'b1100_1100, 1'b0} || r[39:0] !== {8'd20, 8'd10, 8'd0, 8'd0, 8'd0}) begin
                fails++;
                $display("FAIL basic_first: got %h required x=0 y=0 sof pos=cc col=140a000000", r);
            end
            r = got_q[12];
            tests_run++;
            if (r[73:40] !== {12'd2, 12'd2, 2'b00, 8'h00} || r[39:0] !== {8'd42, 8'd32, 8'd22, 8'd12, 8'd2}) begin
                fails++;
                $display("FAIL basic_middle: got %h required x=2 y=2 pos=00 col=2a20160c02", r);
            end
            r = got_q[24];
            tests_run++;
            if (r[73:40] !== {12'd4, 12'd4, 2'b01, 8'b0011_0011} || r[39:0] !== {8'd0, 8'd0, 8'd44, 8'd34, 8'd24}) begin
                fails++;
                $display("FAIL basic_last: got %h required x=4 y=4 eof pos=33 col=00002c2218", r);
            end
        end
    endtask

    task automatic stall_proc();
        int n;
        logic [REC_W-1:0] snap;
        n = 0;
        while (!(got_q.size() >= 5 && out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b0;
        snap = {out_x, out_y, out_sof, out_eof, out_pos, out_col};
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_x, out_y, out_sof, out_eof, out_pos, out_col} !== snap) begin
                fails++;
                $display("FAIL stall_hold: in_ready=%b valid=%b out=%h required 0 1 %h", in_ready, out_valid,
                         {out_x, out_y, out_sof, out_eof, out_pos, out_col}, snap);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_stall();
        int wt;
        exp_q.delete();
        got_q.delete();
        rdy_mode = 2;
        out_ready = 1'b1;
        gen_image(5, 5, 1'b1);
        build_expected(5, 5);
        fork
            send_frame(5, 5, 25, -1, 1'b0, wt);
            stall_proc();
        join
        wait_drain(25, 200);
        tests_run++;
        if (got_q.size() !== 25) begin
            fails++;
            $display("FAIL stall_count: got %0d columns required 25", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL stall_col[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        rdy_mode = 0;
    endtask

    task automatic test_flush();
        int wt;
        exp_q.delete();
        got_q.delete();
        rdy_mode = 0;
        gen_image(6, 5, 1'b0);
        build_expected(6, 5);
        send_frame(6, 5, 30, -1, 1'b0, wt);
        gen_image(5, 5, 1'b0);
        build_expected(5, 5);
        send_frame(5, 5, 25, -1, 1'b0, wt);
        tests_run++;
        if (wt !== 12) begin
            fails++;
            $display("FAIL flush_in_ready_low: in_ready low for %0d cycles required 12", wt);
        end
        wait_drain(55, 400);
        tests_run++;
        if (got_q.size() !== 55) begin
            fails++;
            $display("FAIL flush_count: got %0d columns required 55", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL flush_col[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int wt;
        exp_q.delete();
        rdy_mode = 1;
        gen_image(8, 8, 1'b0);
        send_frame(8, 8, 30, -1, 1'b1, wt);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_state: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        gen_image(5, 5, 1'b0);
        build_expected(5, 5);
        send_frame(5, 5, 25, -1, 1'b1, wt);
        wait_drain(25, 400);
        tests_run++;
        if (got_q.size() !== 25) begin
            fails++;
            $display("FAIL reset_mid_count: got %0d columns required 25", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL reset_mid_col[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_wide();
        int wt;
        int bad;
        logic [REC_W-1:0] r;
        exp_q.delete();
        got_q.delete();
        rdy_mode = 1;
        gen_image(4096, 5, 1'b0);
        build_expected(4096, 5);
        send_frame(4096, 5, 4096 * 5, -1, 1'b1, wt);
        wait_drain(4096 * 5, 20000);
        tests_run++;
        if (got_q.size() !== 4096 * 5) begin
            fails++;
            $display("FAIL wide_count: got %0d columns required %0d", got_q.size(), 4096 * 5);
        end
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                if (bad < 10) $display("FAIL wide_col[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
                bad++;
            end
        end
        if (got_q.size() >= 4096 * 3) begin
            r = got_q[2 * 4096 + 4094];
            tests_run++;
            if (r[73:40] !== {12'd4094, 12'd2, 2'b00, 8'b0001_0000}) begin
                fails++;
                $display("FAIL wide_x4094: got %h required x=4094 y=2 pos=10", r[73:40]);
            end
            r = got_q[2 * 4096 + 4095];
            tests_run++;
            if (r[73:40] !== {12'd4095, 12'd2, 2'b00, 8'b0011_0000}) begin
                fails++;
                $display("FAIL wide_x4095: got %h required x=4095 y=2 pos=30", r[73:40]);
            end
        end
        rdy_mode = 0;
    endtask

    task automatic test_stray_sof();
        int wt;
        exp_q.delete();
        got_q.delete();
        rdy_mode = 0;
        cfg_w = 13'd5;
        cfg_h = 13'd5;
        repeat ($urandom_range(2, 4)) put_pixel(8'($urandom_range(0, 255)), 1'b0, wt);
        tests_run++;
        if (dbg_state !== 2'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stray_idle: state=%0d valid=%b required 0 0", dbg_state, out_valid);
        end
        gen_image(5, 5, 1'b0);
        build_expected(5, 5);
        send_frame(5, 5, 25, 17, 1'b0, wt);
        wait_drain(25, 200);
        tests_run++;
        if (got_q.size() !== 25) begin
            fails++;
            $display("FAIL stray_count: got %0d columns required 25", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL stray_col[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_flush();
        test_reset_mid();
        test_wide();
        test_stray_sof();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Upstream stage of the 5x5 convolution datapath.
- Accepts a raster-order pixel stream and buffers the last four image rows.
- For every image pixel, in raster order, emits the vertical 5-pixel column centred on it: a conv_pkg::pixel_span_t plus a conv_pkg::kernel_pos_t of frame-edge flags.
- The downstream kernel assembler shifts these columns into a 5x5 kernel_t.

Parameters:
- LINE_MAX_W, conv_pkg::IMAGE_MAX_W (4096): maximum frame width in pixels; sets the depth of each line store.
- FRAME_MAX_H, conv_pkg::IMAGE_MAX_H (4096): maximum frame height; sizes the row counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_w  in  13  frame width W, sampled when SOF is accepted; legal range 5..LINE_MAX_W.
- cfg_h  in  13  frame height H, sampled when SOF is accepted; legal range 5..FRAME_MAX_H.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input pixel accepted when in_valid && in_ready.
- in_sof  in  1  marks the first pixel of a frame.
- in_pixel  in  PIXEL_W  input pixel (conv_pkg::pixel_t).
- out_valid  out  1  output column valid.
- out_ready  in  1  downstream accept.
- out_col  out  5*PIXEL_W  pixel_span_t; index 0=N2, 1=N1, 2=X, 3=S1, 4=S2.
- out_pos  out  KERNEL_POS_W  kernel_pos_t edge flags for the centre pixel.
- out_x  out  12  centre column.
- out_y  out  12  centre row.
- out_sof  out  1  high on the column for centre (0,0).
- out_eof  out  1  high on the column for centre (W-1,H-1).

Behaviour:
- Storage: four line stores, each LINE_MAX_W x PIXEL_W, used as a ring. Image row r is written to slot r mod 4.
  - Reads are read-before-write: a same-cycle write to the address being read returns the old data.
  - Store contents are not reset.
- FSM states: IDLE, FILL, RUN, FLUSH. Reset enters IDLE and clears all counters.
  - IDLE: in_ready=1. Pixels without in_sof are consumed and dropped. A pixel with in_sof latches cfg_w/cfg_h, is stored as (0,0), and the FSM enters FILL.
  - FILL: in_ready=1. Rows 0 and 1 are stored; no output is produced. After pixel (W-1,1) the FSM enters RUN.
  - RUN: covers input rows 2..H-1. Accepting pixel (x, y+2) produces the output column for centre (x,y): lanes are rows y-2..y+1 from the stores plus the incoming pixel. After input pixel (W-1,H-1) the FSM enters FLUSH.
  - FLUSH: in_ready=0. Emits 2*W columns for centre rows H-2 and H-1 from stored rows only, then returns to IDLE.
- in_sof outside IDLE is ignored; that pixel is treated as ordinary data.
- Output register (single stage):
  - Latency: the input handshake at cycle t gives out_valid at t+1.
  - in_ready in RUN = !out_valid || out_ready.
  - In FLUSH, the output register advances under the same condition.
  - While out_valid && !out_ready, all out_* fields hold stable.
- Edge flags: a flag=1 means that neighbour lies outside the frame.
  - w1 = x<1, w2 = x<2.
  - e1 = x>W-2, e2 = x>W-3.
  - n1 = y<1, n2 = y<2.
  - s1 = y>H-2, s2 = y>H-3.
- Any out_col lane whose row is outside the frame is driven to 0. Horizontal edges are not zeroed here; that is left to downstream.
- Counters: x wraps from W-1 to 0 and increments y. Input and output coordinate counters are separate. Widths are exactly $clog2 of the max values, with no overflow for legal cfg.
- Reset values: out_valid=0, out_sof=0, out_eof=0, out_col=0, out_pos=0, out_x=0, out_y=0. in_ready=1 in the cycle after rst deasserts.
- Reset mid-frame: the next cycle is IDLE with out_valid=0. No residual output, and the partial frame is discarded.
- cfg_w/cfg_h changes after SOF have no effect until the next SOF.

Test Plan:
- W=5, H=5, pixel=10*y+x, out_ready=1 → exactly 25 columns in raster order.
  - First column: (0,0), out_col={0,0,0,10,20}, out_pos w1,w2,n1,n2=1, others 0, out_sof=1.
  - Last column: (4,4), out_col={24,34,44,0,0}, e1,e2,s1,s2=1, out_eof=1.
  - Middle column: (2,2), col={2,12,22,32,42}, out_pos=0.
- Same frame with out_ready low for 3 cycles mid-RUN → in_ready low for those cycles, output fields held stable, no pixel lost or duplicated; the sequence still matches the previous scenario.
- in_valid held high through FLUSH with W=6, H=5 → in_ready=0 for 12 output columns. The next pixel with in_sof starts a new frame and the first output shows the new frame's data.
- rst pulsed during RUN of frame A (W=8, H=8), then frame B (W=5, H=5) sent → only B's 25 columns appear, correct values.
- W=4096, H=5 → columns x=4094 (e2=1, e1=0) and x=4095 (e1=e2=1) correct. Line store wrap and ring slot reuse correct across rows 4..0.
- Stray pixels without in_sof in IDLE, then in_sof mid-RUN → IDLE strays dropped. The mid-RUN sof pixel is stored as normal data, with no restart.
